// File: rtl/dma_pkg.sv
// rtl/dma_pkg.sv - shared widths, AW entry layout and interrupt gate states for the DMA write joiner
package dma_pkg;

    localparam int DMA_ADDR_W = 32;
    localparam int DMA_DATA_W = 64;
    localparam int DMA_USER_W = 16;

    typedef struct packed {
        logic [DMA_ADDR_W-1:0] addr;
        logic [DMA_USER_W-1:0] user;
    } aw_entry_t;

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        ASSERT
    } gate_state_t;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with registered storage and full/empty flags
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    // One extra pointer bit tells full from empty when the indices match.
    logic [PW:0]      wr_ptr;
    logic [PW:0]      rd_ptr;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign pop_data = mem[rd_ptr[PW-1:0]];

    // Advance pointers; a push into a full FIFO or a pop from an empty one is ignored.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr <= wr_ptr + (PW+1)'(1);
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + (PW+1)'(1);
            end
        end
    end

    // Storage needs no reset: entries are only visible between the pointers.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_ptr[PW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/dma_wr_joiner.sv
// rtl/dma_wr_joiner.sv - pairs DMA AW and W beats into filtered memory writes and gates the completion interrupt
module dma_wr_joiner
    import dma_pkg::*;
#(
    parameter int          AW_DEPTH  = 4,
    parameter int          W_DEPTH   = 4,
    parameter logic [31:0] ADDR_BASE = 32'h8000_0000,
    parameter logic [31:0] ADDR_SIZE = 32'h0100_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        s_awvalid,
    output logic        s_awready,
    input  logic [31:0] s_awaddr,
    input  logic [15:0] s_awuser,
    input  logic        s_wvalid,
    output logic        s_wready,
    input  logic [63:0] s_wdata,
    input  logic        dma_intr,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [31:0] m_addr,
    output logic [63:0] m_data,
    output logic [15:0] m_user,
    output logic        intr,
    output logic [31:0] wr_cnt,
    output logic [15:0] err_cnt,
    output logic        err
);

    // Upper bound of the legal window, kept in 33 bits so a window ending at 4 GiB does not wrap.
    localparam logic [32:0] ADDR_LIMIT = {1'b0, ADDR_BASE} + {1'b0, ADDR_SIZE};

    aw_entry_t              aw_in;
    aw_entry_t              aw_head;
    logic [DMA_DATA_W-1:0]  w_head;
    logic                   aw_full;
    logic                   aw_empty;
    logic                   w_full;
    logic                   w_empty;
    logic                   aw_push;
    logic                   w_push;
    logic                   pair_pop;
    logic                   pair_legal;
    gate_state_t            state;
    gate_state_t            state_next;

    assign s_awready = ~reset & ~aw_full;
    assign s_wready  = ~reset & ~w_full;
    assign aw_push   = s_awvalid & s_awready;
    assign w_push    = s_wvalid & s_wready;

    assign aw_in.addr = s_awaddr;
    assign aw_in.user = s_awuser;

    sync_fifo #(
        .WIDTH ($bits(aw_entry_t)),
        .DEPTH (AW_DEPTH)
    ) u_aw_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (aw_push),
        .push_data (aw_in),
        .pop       (pair_pop),
        .pop_data  (aw_head),
        .full      (aw_full),
        .empty     (aw_empty)
    );

    sync_fifo #(
        .WIDTH (DMA_DATA_W),
        .DEPTH (W_DEPTH)
    ) u_w_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (w_push),
        .push_data (s_wdata),
        .pop       (pair_pop),
        .pop_data  (w_head),
        .full      (w_full),
        .empty     (w_empty)
    );

    // A pair leaves both FIFOs together once the output stage is free or being drained.
    assign pair_pop   = ~aw_empty & ~w_empty & (~m_valid | m_ready);
    assign pair_legal = (aw_head.addr >= ADDR_BASE)
                      && ({1'b0, aw_head.addr} < ADDR_LIMIT)
                      && (aw_head.addr[2:0] == 3'b000);

    // Output request register: legal pairs load it, illegal pairs only retire the current request.
    always_ff @(posedge clk) begin
        if (reset) begin
            m_valid <= 1'b0;
            m_addr  <= '0;
            m_data  <= '0;
            m_user  <= '0;
        end else if (pair_pop) begin
            m_valid <= pair_legal;
            if (pair_legal) begin
                m_addr <= aw_head.addr;
                m_data <= w_head;
                m_user <= aw_head.user;
            end
        end else if (m_ready) begin
            m_valid <= 1'b0;
        end
    end

    // Traffic counters: completed writes wrap, dropped writes saturate and latch the sticky flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_cnt  <= '0;
            err_cnt <= '0;
            err     <= 1'b0;
        end else begin
            if (m_valid && m_ready) begin
                wr_cnt <= wr_cnt + 32'd1;
            end
            if (pair_pop && !pair_legal) begin
                err <= 1'b1;
                if (err_cnt != 16'hFFFF) begin
                    err_cnt <= err_cnt + 16'd1;
                end
            end
        end
    end

    // Interrupt gate state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Interrupt gate: hold the DMA interrupt back until nothing accepted is still in flight.
    always_comb begin
        state_next = state;
        intr       = 1'b0;
        case (state)
            IDLE: begin
                if (dma_intr) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (!dma_intr) begin
                    state_next = IDLE;
                end else if (aw_empty && w_empty && !m_valid) begin
                    state_next = ASSERT;
                end
            end
            ASSERT: begin
                intr = 1'b1;
                if (!dma_intr) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_dma_wr_joiner.sv
// tb/tb_dma_wr_joiner.sv - randomized and directed self-checking bench for dma_wr_joiner
module tb_dma_wr_joiner;

    logic        clk;
    logic        reset;
    logic        s_awvalid;
    logic        s_awready;
    logic [31:0] s_awaddr;
    logic [15:0] s_awuser;
    logic        s_wvalid;
    logic        s_wready;
    logic [63:0] s_wdata;
    logic        dma_intr;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_addr;
    logic [63:0] m_data;
    logic [15:0] m_user;
    logic        intr;
    logic [31:0] wr_cnt;
    logic [15:0] err_cnt;
    logic        err;

    dma_wr_joiner dut (
        .clk       (clk),
        .reset     (reset),
        .s_awvalid (s_awvalid),
        .s_awready (s_awready),
        .s_awaddr  (s_awaddr),
        .s_awuser  (s_awuser),
        .s_wvalid  (s_wvalid),
        .s_wready  (s_wready),
        .s_wdata   (s_wdata),
        .dma_intr  (dma_intr),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_addr    (m_addr),
        .m_data    (m_data),
        .m_user    (m_user),
        .intr      (intr),
        .wr_cnt    (wr_cnt),
        .err_cnt   (err_cnt),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: accepted beats queue up per channel, pair in order, legal pairs become expected requests.
    typedef struct packed {
        logic [31:0] a;
        logic [63:0] d;
        logic [15:0] u;
    } req_t;

    logic [47:0] aw_q[$];
    logic [63:0] w_q[$];
    req_t        exp_q[$];
    int          legal_cnt;
    int          illegal_cnt;
    logic        hold_prev;
    req_t        hold_req;

    function automatic bit is_legal(input logic [31:0] a);
        longint unsigned x;
        x = longint'(a);
        return (x >= 64'h8000_0000) && (x < 64'h8000_0000 + 64'h0100_0000) && (x % 8 == 0);
    endfunction

    // Sample half a cycle away from the active edge; handshakes seen here complete at the next rising edge.
    always @(negedge clk) begin
        if (reset) begin
            aw_q.delete();
            w_q.delete();
            exp_q.delete();
            legal_cnt   = 0;
            illegal_cnt = 0;
            hold_prev   = 1'b0;
        end else begin
            if (hold_prev) begin
                chk("hold_valid", {63'd0, m_valid}, 64'd1);
                chk("hold_addr", {32'd0, m_addr}, {32'd0, hold_req.a});
                chk("hold_data", m_data, hold_req.d);
                chk("hold_user", {48'd0, m_user}, {48'd0, hold_req.u});
            end
            if (s_awvalid && s_awready) aw_q.push_back({s_awaddr, s_awuser});
            if (s_wvalid && s_wready) w_q.push_back(s_wdata);
            while (aw_q.size() > 0 && w_q.size() > 0) begin
                logic [47:0] awe;
                logic [63:0] we;
                awe = aw_q.pop_front();
                we  = w_q.pop_front();
                if (is_legal(awe[47:16])) begin
                    exp_q.push_back({awe[47:16], we, awe[15:0]});
                    legal_cnt++;
                end else begin
                    illegal_cnt++;
                end
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_req", {32'd0, m_addr}, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    req_t e;
                    e = exp_q.pop_front();
                    chk("req_addr", {32'd0, m_addr}, {32'd0, e.a});
                    chk("req_data", m_data, e.d);
                    chk("req_user", {48'd0, m_user}, {48'd0, e.u});
                end
            end
            hold_prev = m_valid && !m_ready;
            hold_req  = {m_addr, m_data, m_user};
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_aw(input logic [31:0] a, input logic [15:0] u);
        int t;
        s_awvalid = 1'b1;
        s_awaddr  = a;
        s_awuser  = u;
        t = 0;
        @(negedge clk);
        while (!s_awready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) chk("aw_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        s_awvalid = 1'b0;
    endtask

    task automatic push_w(input logic [63:0] d);
        int t;
        s_wvalid = 1'b1;
        s_wdata  = d;
        t = 0;
        @(negedge clk);
        while (!s_wready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) chk("w_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        s_wvalid = 1'b0;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        s_awvalid = 1'b0;
        s_wvalid  = 1'b0;
        dma_intr  = 1'b0;
        tick(2);
        reset = 1'b0;
        #1;
    endtask

    function automatic logic [31:0] rand_addr();
        int r;
        r = $urandom_range(0, 9);
        if (r < 7) return 32'h8000_0000 + ($urandom_range(0, 32'h001F_FFFF) << 3);
        case ($urandom_range(0, 3))
            0: return 32'h7FFF_FFF8;
            1: return 32'h8000_0000 + ($urandom_range(0, 32'h00FF_FFFF) | 32'd1);
            2: return 32'h8100_0000 + ($urandom_range(0, 255) << 3);
            default: return $urandom;
        endcase
    endfunction

    task automatic rand_aw(input int n);
        for (int i = 0; i < n; i++) begin
            tick($urandom_range(0, 2));
            push_aw(rand_addr(), 16'($urandom));
        end
    endtask

    task automatic rand_w(input int n);
        for (int i = 0; i < n; i++) begin
            tick($urandom_range(0, 2));
            push_w({$urandom, $urandom});
        end
    endtask

    bit done;

    initial begin
        reset     = 1'b1;
        s_awvalid = 1'b0;
        s_awaddr  = '0;
        s_awuser  = '0;
        s_wvalid  = 1'b0;
        s_wdata   = '0;
        dma_intr  = 1'b0;
        m_ready   = 1'b1;
        tick(2);

        // Reset state
        chk("rst_m_valid", {63'd0, m_valid}, 64'd0);
        chk("rst_intr", {63'd0, intr}, 64'd0);
        chk("rst_wr_cnt", {32'd0, wr_cnt}, 64'd0);
        chk("rst_err_cnt", {48'd0, err_cnt}, 64'd0);
        chk("rst_err", {63'd0, err}, 64'd0);
        chk("rst_awready", {63'd0, s_awready}, 64'd0);
        chk("rst_wready", {63'd0, s_wready}, 64'd0);
        reset = 1'b0;
        #1;
        chk("post_rst_awready", {63'd0, s_awready}, 64'd1);
        chk("post_rst_wready", {63'd0, s_wready}, 64'd1);

        // Single write and its latency
        fork
            push_aw(32'h8000_0010, 16'd1);
            push_w(64'hDEAD_BEEF_0000_0001);
        join
        chk("lat_n1_valid", {63'd0, m_valid}, 64'd0);
        tick(1);
        chk("lat_n2_valid", {63'd0, m_valid}, 64'd1);
        chk("single_addr", {32'd0, m_addr}, 64'h8000_0010);
        chk("single_data", m_data, 64'hDEAD_BEEF_0000_0001);
        chk("single_user", {48'd0, m_user}, 64'd1);
        tick(1);
        chk("single_wr_cnt", {32'd0, wr_cnt}, 64'd1);
        chk("single_err", {63'd0, err}, 64'd0);

        // AW runs a full FIFO ahead of W
        do_reset();
        for (int i = 0; i < 4; i++) push_aw(32'h8000_0000 + 32'(8 * i), 16'(i + 16));
        chk("skew_awready_full", {63'd0, s_awready}, 64'd0);
        chk("skew_wready", {63'd0, s_wready}, 64'd1);
        for (int i = 0; i < 4; i++) push_w(64'h1000 + 64'(i));
        tick(4);
        chk("skew_wr_cnt", {32'd0, wr_cnt}, 64'd4);
        chk("skew_drained", 64'(exp_q.size()), 64'd0);

        // Backpressure holds the first request
        do_reset();
        m_ready = 1'b0;
        fork
            for (int i = 0; i < 3; i++) push_aw(32'h8000_0100 + 32'(8 * i), 16'(i));
            for (int i = 0; i < 3; i++) push_w(64'hA0A0_0000_0000_0000 + 64'(i));
        join
        tick(1);
        for (int i = 0; i < 10; i++) begin
            chk("bp_addr", {32'd0, m_addr}, 64'h8000_0100);
            chk("bp_data", m_data, 64'hA0A0_0000_0000_0000);
            tick(1);
        end
        m_ready = 1'b1;
        tick(5);
        chk("bp_wr_cnt", {32'd0, wr_cnt}, 64'd3);
        chk("bp_drained", 64'(exp_q.size()), 64'd0);

        // Illegal addresses are dropped and counted
        do_reset();
        push_aw(32'h7FFF_FFF8, 16'd7);
        push_aw(32'h8000_0004, 16'd8);
        push_aw(32'h8100_0000, 16'd9);
        for (int i = 0; i < 3; i++) push_w(64'hBAD0 + 64'(i));
        tick(3);
        chk("ill_err_cnt", {48'd0, err_cnt}, 64'd3);
        chk("ill_err", {63'd0, err}, 64'd1);
        chk("ill_wr_cnt", {32'd0, wr_cnt}, 64'd0);
        fork
            push_aw(32'h80FF_FFF8, 16'h55);
            push_w(64'h600D);
        join
        tick(3);
        chk("ill_next_wr_cnt", {32'd0, wr_cnt}, 64'd1);
        chk("ill_err_sticky", {63'd0, err}, 64'd1);

        // Interrupt held until the last buffered write is handed over
        do_reset();
        m_ready = 1'b0;
        fork
            for (int i = 0; i < 2; i++) push_aw(32'h8000_0200 + 32'(8 * i), 16'(i));
            for (int i = 0; i < 2; i++) push_w(64'h5000 + 64'(i));
        join
        dma_intr = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            chk("intr_blocked", {63'd0, intr}, 64'd0);
        end
        m_ready = 1'b1;
        tick(1);
        chk("intr_after_hs1", {63'd0, intr}, 64'd0);
        tick(1);
        chk("intr_after_hs2", {63'd0, intr}, 64'd0);
        tick(1);
        chk("intr_raised", {63'd0, intr}, 64'd1);
        dma_intr = 1'b0;
        tick(1);
        chk("intr_lowered", {63'd0, intr}, 64'd0);

        // dma_intr withdrawn during drain never reaches the CPU
        m_ready = 1'b0;
        fork
            push_aw(32'h8000_0300, 16'd3);
            push_w(64'h7777);
        join
        dma_intr = 1'b1;
        tick(2);
        dma_intr = 1'b0;
        tick(1);
        m_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            chk("intr_aborted", {63'd0, intr}, 64'd0);
        end

        // Reset mid-stream discards everything buffered
        do_reset();
        m_ready = 1'b0;
        fork
            for (int i = 0; i < 4; i++) push_aw(32'h8000_0400 + 32'(8 * i), 16'(i));
            for (int i = 0; i < 4; i++) push_w(64'h9000 + 64'(i));
        join
        tick(1);
        chk("mid_pre_valid", {63'd0, m_valid}, 64'd1);
        reset = 1'b1;
        #1;
        chk("mid_awready_rst", {63'd0, s_awready}, 64'd0);
        tick(1);
        chk("mid_valid", {63'd0, m_valid}, 64'd0);
        chk("mid_wr_cnt", {32'd0, wr_cnt}, 64'd0);
        chk("mid_wready_rst", {63'd0, s_wready}, 64'd0);
        reset = 1'b0;
        #1;
        chk("mid_awready_after", {63'd0, s_awready}, 64'd1);
        chk("mid_wready_after", {63'd0, s_wready}, 64'd1);
        m_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            chk("mid_no_stale", {63'd0, m_valid}, 64'd0);
        end
        chk("mid_wr_cnt_after", {32'd0, wr_cnt}, 64'd0);

        // Randomized traffic with random backpressure
        do_reset();
        done = 1'b0;
        fork
            begin
                fork
                    rand_aw(150);
                    rand_w(150);
                join
                done = 1'b1;
            end
            begin
                while (!done) begin
                    tick(1);
                    m_ready = ($urandom_range(0, 3) != 0);
                end
                m_ready = 1'b1;
            end
        join
        tick(10);
        chk("rnd_drained", 64'(exp_q.size()), 64'd0);
        chk("rnd_wr_cnt", {32'd0, wr_cnt}, 64'(legal_cnt));
        chk("rnd_err_cnt", {48'd0, err_cnt}, 64'(illegal_cnt));
        chk("rnd_err", {63'd0, err}, {63'd0, illegal_cnt != 0});
        chk("rnd_total", 64'(legal_cnt + illegal_cnt), 64'd150);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
